keypad_matrix_scanner: RTL
==========================

# keypad_matrix_scanner

Scans a 4x4 active-low key matrix by driving one-hot row strobes and sampling the column returns, the input-side counterpart of the LED matrix row-scan drivers. It synchronises and debounces the columns, rejects multi-key (ghost) frames, and reports each debounced press as a code plus a one-cycle valid pulse. It sits between the keypad pins and the game FSM that consumes code entry.

## Interface
- `ROWS`, 4: row strobe count.
- `COLS`, 4: column return count.
- `SCAN_DIV`, 4: clocks each row stays strobed. Must be at least 3.
- `DEBOUNCE`, 3: consecutive identical frames needed to accept a press or a release. Must be at least 1.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row`  out  ROWS  row strobes, registered, active-low one-hot.
- `col`  in  COLS  column returns, active-low, asynchronous to `clk`.
- `key_code`  out  $clog2(ROWS*COLS)  last accepted key, equal to row_idx*COLS + col_idx.
- `key_valid`  out  1  one-cycle pulse when a new press is accepted.
- `key_held`  out  1  high from acceptance until the debounced release.

## Operation
- `col` passes through a 2-flop synchroniser before any use.
- Row pointer `rp` (0..ROWS-1) advances each time dwell counter `dc` reaches SCAN_DIV-1. `dc` then returns to 0, and `rp` wraps from ROWS-1 to 0.
- `row` equals the bitwise inverse of (1 << `rp`), registered.
- Sample point is the cycle where `dc` == SCAN_DIV-1. The synchronised columns are read for the current `rp`.
- Per frame (one full pass over all rows), the block accumulates:
  - the count of asserted keys, saturating at 2;
  - the code of the first asserted key.
- Frame class:
  - NONE when the count is 0.
  - SINGLE(code) when the count is 1.
  - MULTI when the count is 2 or more.
- The FSM is evaluated once per frame, in the cycle after the last sample (`frame_end`).
- A debounce counter `cnt` saturates at DEBOUNCE.
- FSM states and transitions:
  - IDLE:
    - SINGLE(c) loads candidate=c, sets `cnt`=1, goes to DEB.
    - If DEBOUNCE==1, SINGLE(c) instead accepts immediately (see DEB).
    - NONE or MULTI stays in IDLE.
  - DEB:
    - SINGLE(candidate) increments `cnt`. When `cnt` reaches DEBOUNCE:
      - `key_code` is set to candidate;
      - `key_valid` pulses;
      - `key_held` is set to 1;
      - the FSM goes to PRESSED.
    - Any other class goes to IDLE with `cnt` cleared.
  - PRESSED:
    - NONE sets `cnt`=1 and goes to REL.
    - SINGLE(any) or MULTI stays in PRESSED. A second key while one is held never produces an event.
  - REL:
    - NONE increments `cnt`. At DEBOUNCE, `key_held` clears and the FSM goes to IDLE.
    - SINGLE or MULTI returns to PRESSED with `cnt` cleared. This is treated as release bounce, and no new `key_valid` is produced.
- Reset (asynchronous, at any time, including mid-frame or mid-debounce) sets:
  - `rp`=0, `dc`=0, synchroniser flops all 1, frame accumulators cleared, FSM IDLE, `cnt`=0;
  - `row`=~1 (4'b1110 at defaults), `key_code`=0, `key_valid`=0, `key_held`=0.

## Timing
- Frame length is ROWS*SCAN_DIV clocks (16 at defaults).
- After reset release, the first sample is on cycle SCAN_DIV-1 and the first `frame_end` is on cycle ROWS*SCAN_DIV.
- Column-to-sample latency is 2 clocks (synchroniser). This is why SCAN_DIV must be at least 3: the sampled value reflects the currently strobed row.
- `key_valid` and the `key_code` update occur in the same cycle, the `frame_end` of the DEBOUNCE-th consecutive SINGLE frame.
- `key_code` holds its value until the next acceptance.
- `key_held` falls at the `frame_end` of the DEBOUNCE-th consecutive NONE frame.
- `key_valid` is never high in two consecutive cycles.
- `row` changes only on the `dc` wrap edge and is glitch-free (registered).

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, DEB, PRESSED, REL);
  - the frame-class enum (NONE, SINGLE, MULTI);
  - default constants KP_ROWS=4, KP_COLS=4.
- One natural sub-module: `keypad_row_scanner`, which owns `dc`, `rp`, `row` and emits `sample_en`, `frame_end` and `rp`. The debounce FSM stays in the top level.

## Test plan
- Reset, no keys pressed: `row` cycles through 1110, 1101, 1011, 0111 with each pattern held 4 clocks. `key_valid` stays 0 and `key_held` stays 0 indefinitely.
- Key row 2 / col 1 pressed before the first frame and held: `key_code`=9 and `key_valid` pulses exactly once at the end of frame 3 (cycle 48). `key_held`=1.
- Same key released after acceptance: `key_held` falls at the 3rd all-NONE `frame_end`. No `key_valid` on release.
- Key 5 bounces (present 1 frame, absent 1 frame, repeatedly), then is stable: no pulse until 3 consecutive SINGLE(5) frames, then a single pulse with `key_code`=5.
- Keys 0 and 15 pressed together: MULTI frames and no `key_valid`. Release key 15: key 0 is accepted after 3 frames with `key_code`=0.
- Reset asserted while the FSM is in DEB: all outputs return to reset values at once, and `row` returns to 1110. After release, the full 3-frame debounce restarts.

Source files
------------

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and default geometry for the keypad matrix scanner.
//   kp_state_e : debounce FSM states
//   kp_class_e : classification of one full scan frame
package keypad_matrix_scanner_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        PRESSED,
        REL
    } kp_state_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } kp_class_e;

endpackage

// File: rtl/keypad_matrix_scanner_row_scanner.sv
// Row strobe generator: holds each row low for SCAN_DIV clocks, round robin.
//   clk, rst_n : clock, async active-low reset
//   row        : registered active-low one-hot row strobes
//   rp         : index of the row currently strobed
//   sample_en  : last dwell cycle of the current row (columns are read here)
//   frame_end  : one cycle after the sample of the last row
module keypad_row_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int unsigned ROWS     = KP_ROWS,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ROWS-1:0]           row,
    output logic [$clog2(ROWS)-1:0]   rp,
    output logic                      sample_en,
    output logic                      frame_end
);

    localparam int unsigned RPW = $clog2(ROWS);
    localparam int unsigned DCW = $clog2(SCAN_DIV);
    localparam logic [DCW-1:0] DC_LAST = DCW'(SCAN_DIV - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(ROWS - 1);

    logic [DCW-1:0]  dc_q, dc_d;
    logic [RPW-1:0]  rp_q, rp_d;
    logic [ROWS-1:0] row_q, row_d;
    logic            frame_end_q, frame_end_d;
    logic            at_sample;

    always_comb begin
        at_sample   = (dc_q == DC_LAST);
        dc_d        = dc_q + DCW'(1);
        rp_d        = rp_q;
        if (at_sample) begin
            dc_d = '0;
            rp_d = (rp_q == RP_LAST) ? '0 : rp_q + RPW'(1);
        end
        // Strobe follows the next pointer so row and rp change on the same edge.
        row_d       = ~(ROWS'(1) << rp_d);
        frame_end_d = at_sample && (rp_q == RP_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q        <= '0;
            rp_q        <= '0;
            row_q       <= ~ROWS'(1);
            frame_end_q <= 1'b0;
        end else begin
            dc_q        <= dc_d;
            rp_q        <= rp_d;
            row_q       <= row_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign row       = row_q;
    assign rp        = rp_q;
    assign sample_en = at_sample;
    assign frame_end = frame_end_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner with column synchroniser, ghost rejection
// and press/release debounce.
//   clk, rst_n : clock, async active-low reset
//   row        : active-low one-hot row strobes (registered)
//   col        : active-low column returns, asynchronous
//   key_code   : last accepted key, row_idx*COLS + col_idx
//   key_valid  : one-cycle pulse per accepted press
//   key_held   : high from acceptance until debounced release
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int unsigned ROWS     = KP_ROWS,
    parameter int unsigned COLS     = KP_COLS,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ROWS-1:0]               row,
    input  logic [COLS-1:0]               col,
    output logic [$clog2(ROWS*COLS)-1:0]  key_code,
    output logic                          key_valid,
    output logic                          key_held
);

    localparam int unsigned CW   = $clog2(ROWS*COLS);
    localparam int unsigned RPW  = $clog2(ROWS);
    localparam int unsigned CNTW = $clog2(DEBOUNCE + 1);
    localparam logic [CNTW-1:0] CNT_DONE = CNTW'(DEBOUNCE);

    logic [RPW-1:0] rp;
    logic           sample_en;
    logic           frame_end;

    keypad_row_scanner #(
        .ROWS     (ROWS),
        .SCAN_DIV (SCAN_DIV)
    ) u_row_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .rp        (rp),
        .sample_en (sample_en),
        .frame_end (frame_end)
    );

    logic [COLS-1:0] col_s1_q, col_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
        end
    end

    // Frame accumulators: key count saturating at 2, code of first key seen.
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [CW-1:0] acc_code_q, acc_code_d;

    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (sample_en) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (!col_s2_q[c]) begin
                    if (acc_cnt_d == 2'd0) begin
                        acc_code_d = CW'(rp * COLS + c);
                    end
                    if (acc_cnt_d != 2'd2) begin
                        acc_cnt_d = acc_cnt_d + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
        end
    end

    kp_class_e frame_class;

    always_comb begin
        unique case (acc_cnt_q)
            2'd0:    frame_class = CLS_NONE;
            2'd1:    frame_class = CLS_SINGLE;
            default: frame_class = CLS_MULTI;
        endcase
    end

    kp_state_e     state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] cand_q, cand_d;
    logic [CW-1:0] key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cnt_inc     = cnt_q + CNTW'(1);

        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_class == CLS_SINGLE) begin
                        cand_d = acc_code_q;
                        if (DEBOUNCE == 1) begin
                            key_code_d  = acc_code_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d   = CNTW'(1);
                            state_d = DEB;
                        end
                    end
                end
                DEB: begin
                    if (frame_class == CLS_SINGLE && acc_code_q == cand_q) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = PRESSED;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (frame_class == CLS_NONE) begin
                        if (DEBOUNCE == 1) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d   = CNTW'(1);
                            state_d = REL;
                        end
                    end
                end
                REL: begin
                    if (frame_class == CLS_NONE) begin
                        if (cnt_inc == CNT_DONE) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Key seen again before release settled: bounce, no new event.
                        cnt_d   = '0;
                        state_d = PRESSED;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
